// File: rtl/filters_pkg.sv
// Shared FIR filter definitions: FSM encoding, DC offset, defaults.
// Also holds the filter-select codes used by the surrounding system.
package filters_pkg;

  localparam int TAPS_DEF      = 23;
  localparam int DATA_W_DEF    = 16;
  localparam int COEF_W_DEF    = 32;
  localparam int COEF_FRAC_DEF = 16;
  localparam int ADDR_W_DEF    = 5;
  localparam int DC_OFFSET     = 2048;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FINAL = 2'd2
  } fir_state_e;

  typedef enum logic [1:0] {
    FILT_LPF = 2'd0,
    FILT_HPF = 2'd1,
    FILT_BPF = 2'd2
  } filt_sel_e;

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear.
// Clear has priority over enable.
module fir_mac #(
  parameter int XW = 17,
  parameter int CW = 32,
  parameter int AW = 54
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [XW-1:0] x,
  input  logic signed [CW-1:0] c,
  output logic signed [AW-1:0] acc
);

  logic signed [XW+CW-1:0] prod;
  logic signed [AW-1:0]    acc_d;
  logic signed [AW-1:0]    acc_q;

  always_comb begin
    prod  = x * c;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + AW'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_engine.sv
// Sequential FIR engine: one MAC per tap over external sample/coef RAMs.
// Define FIR_ENGINE_SAT_EN to clamp the result instead of wrapping.
module fir_engine
  import filters_pkg::*;
#(
  parameter int TAPS      = TAPS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dc_en,
  output logic [ADDR_W-1:0] xant_addr,
  output logic              xant_ce,
  input  logic [DATA_W-1:0] xant_q,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              coef_ce,
  input  logic [COEF_W-1:0] coef_q,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              ready,
  output logic              idle
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS) + 1;
  localparam int XW    = DATA_W + 1;

  fir_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic              vld_q, vld_d;
  logic              fin_q, fin_d;
  logic              dc_q, dc_d;
  logic              clr;

  logic signed [XW-1:0]    off_s;
  logic signed [XW-1:0]    x_s;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] y;
  logic [DATA_W-1:0]       y_out;

  fir_mac #(
    .XW(XW),
    .CW(COEF_W),
    .AW(ACC_W)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (vld_q),
    .x  (x_s),
    .c  ($signed(coef_q)),
    .acc(acc)
  );

  always_comb begin
    off_s = dc_q ? XW'(DC_OFFSET) : '0;
    x_s   = $signed({1'b0, xant_q}) - off_s;
    y     = (acc >>> COEF_FRAC) + ACC_W'(off_s);
`ifdef FIR_ENGINE_SAT_EN
    if (y[ACC_W-1]) begin
      y_out = '0;
    end else if (|y[ACC_W-2:DATA_W]) begin
      y_out = '1;
    end else begin
      y_out = y[DATA_W-1:0];
    end
`else
    y_out = y[DATA_W-1:0];
`endif
  end

`ifndef FIR_ENGINE_SAT_EN
  logic unused_y_hi;
  assign unused_y_hi = ^y[ACC_W-1:DATA_W];
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    result_d = result_q;
    done_d   = 1'b0;
    fin_d    = fin_q;
    dc_d     = dc_q;
    clr      = 1'b0;
    vld_d    = (state_q == ST_READ);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          addr_d  = '0;
          dc_d    = dc_en;
          clr     = 1'b1;
        end
      end
      ST_READ: begin
        if (addr_q == ADDR_W'(TAPS - 1)) begin
          state_d = ST_FINAL;
          addr_d  = '0;
          fin_d   = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_FINAL: begin
        // first cycle folds in the last pair, second emits the result
        if (!fin_q) begin
          fin_d = 1'b1;
        end else begin
          result_d = y_out;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
          fin_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      vld_q    <= 1'b0;
      fin_q    <= 1'b0;
      dc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      result_q <= result_d;
      done_q   <= done_d;
      vld_q    <= vld_d;
      fin_q    <= fin_d;
      dc_q     <= dc_d;
    end
  end

  assign xant_ce   = (state_q == ST_READ);
  assign coef_ce   = (state_q == ST_READ);
  assign xant_addr = addr_q;
  assign coef_addr = addr_q;
  assign result    = result_q;
  assign done      = done_q;
  assign ready     = done_q;
  assign idle      = (state_q == ST_IDLE);

endmodule

// File: doc/fir_engine.md
FIR_ENGINE -- requirements
Module: fir_engine

Interface
REQ-001 SHALL have parameter TAPS, default 23, number of filter taps (sample/coefficient addresses 0..TAPS-1).
REQ-002 SHALL have parameter DATA_W, default 16, sample and result width (unsigned).
REQ-003 SHALL have parameter COEF_W, default 32, coefficient width (signed two's complement).
REQ-004 SHALL have parameter COEF_FRAC, default 16, coefficient fractional bits.
REQ-005 SHALL have parameter ADDR_W, default 5, memory address width.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  request one filter computation (ap_start-style).
REQ-009 dc_en  in  1  1 = remove/re-add DC_OFFSET around the MAC.
REQ-010 xant_addr  out  ADDR_W  sample memory read address.
REQ-011 xant_ce  out  1  sample memory read enable.
REQ-012 xant_q  in  DATA_W  sample read data, valid one cycle after address with ce.
REQ-013 coef_addr  out  ADDR_W  coefficient memory read address.
REQ-014 coef_ce  out  1  coefficient memory read enable.
REQ-015 coef_q  in  COEF_W  coefficient read data, same one-cycle latency.
REQ-016 result  out  DATA_W  filtered sample, held until next done.
REQ-017 done  out  1  one-cycle pulse: result updated this cycle.
REQ-018 ready  out  1  identical to done.
REQ-019 idle  out  1  high while in IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> READ -> FINAL -> IDLE.
REQ-021 IDLE: idle=1, ce=0, addrs=0; start=1 -> READ next cycle; start sampled only in IDLE.
REQ-022 READ: ce=1, both addresses present k=0..TAPS-1 on consecutive cycles, identical values; after TAPS-1 issued -> FINAL.
REQ-023 Accumulator cleared on IDLE->READ; each returned pair adds (x - off) * c, off = DC_OFFSET if dc_en else 0, x zero-extended, signed product.
REQ-024 Accumulator width SHALL be DATA_W+COEF_W+clog2(TAPS)+1; no internal overflow.
REQ-025 FINAL: takes last pair, then y = (acc >>> COEF_FRAC) + off (arithmetic shift, floor); result<=y, done=ready=1 one cycle, -> IDLE.
REQ-026 Latency: start seen at cycle 0 -> done at cycle TAPS+2 (25 at default); back-to-back start accepted in cycle TAPS+3.
REQ-027 start while READ/FINAL SHALL be ignored (not queued).
REQ-028 dc_en SHALL be sampled on IDLE->READ and held for the computation.
REQ-029 result SHALL change only in the done cycle.

Reset
REQ-030 rst low SHALL asynchronously force IDLE, result=0, done=ready=0, ce=0, addrs=0, accumulator=0, idle=1.
REQ-031 Reset mid-computation SHALL abort it; no done pulse for the aborted start.

Configuration
REQ-032 Macro FIR_ENGINE_SAT_EN defined: y clamped to [0, 2^DATA_W-1].
REQ-033 Macro FIR_ENGINE_SAT_EN undefined: result = y[DATA_W-1:0] (wrap).

Structure
REQ-034 Package filters_pkg SHALL hold FSM state encoding, DC_OFFSET (2048), default TAPS/DATA_W/COEF_W/COEF_FRAC/ADDR_W, and the filter-select codes LPF=0, HPF=1, BPF=2.
REQ-035 Signed multiply-accumulate SHALL be sub-module fir_mac (clear, enable, x, c, acc out).

Verification
REQ-036 Reset: rst=0 -> result=0, done=0, idle=1, ce=0; release -> remains IDLE.
REQ-037 coef all 0x0001_0000, xant all 100, dc_en=0, start -> done at cycle 25, result=2300, addrs 0..22 observed once each.
REQ-038 dc_en=1, coef[0]=0x0002_0000 others 0, xant[0]=3048 others 2048 -> result=4048.
REQ-039 coef all 1.0, xant all 4000, dc_en=0 -> 65535 with FIR_ENGINE_SAT_EN, 26464 without; dc_en=1, coef[0]=0xFFFE_0000, xant[0]=4095 -> 0 with SAT (wrapped -2046 without).
REQ-040 start pulsed again at cycle 5 -> ignored, single done at 25; start held high -> done every 26 cycles.
REQ-041 rst asserted at cycle 10 of a computation -> immediate IDLE, no done; next start completes normally with correct result.
